// File: rtl/costas_pkg.sv
// Shared definitions for the Costas-loop demodulator: lock FSM encoding,
// default loop gains and a generic signed saturation helper.
package costas_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    localparam int KP_ACQ_DEF = 5000000;
    localparam int KP_TRK_DEF = 1000000;

    function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                               input logic signed [63:0] lim_lo,
                                               input logic signed [63:0] lim_hi);
        if (v > lim_hi)      return lim_hi;
        else if (v < lim_lo) return lim_lo;
        else                 return v;
    endfunction

endpackage

// File: rtl/costas_demod_v2_nco_square.sv
// Phase-accumulator NCO producing quadrature square waves from the two
// accumulator MSBs; advances only on enabled (valid-sample) cycles.
module nco_square
    import costas_pkg::*;
#(
    parameter int PW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [PW-1:0] i_incr,
    output logic          o_vco_s,
    output logic          o_vco_c
);

    logic [PW-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst)       r_acc <= '0;
        else if (i_en) r_acc <= r_acc + i_incr;
    end

    assign o_vco_s = r_acc[PW-1];
    assign o_vco_c = r_acc[PW-1] ^ r_acc[PW-2];

endmodule

// File: rtl/costas_demod_v2.sv
// Costas-loop BPSK demodulator: square-wave NCO, mixer arms with one-pole LPFs,
// bang-bang loop filter, lock FSM and DC-removed output with a 2-cycle latency.
module costas_demod_v2
    import costas_pkg::*;
#(
    parameter int DW       = 14,
    parameter int PW       = 32,
    parameter int NOM_INCR = 919123001,
    parameter int LPF_SH   = 2,
    parameter int KP_ACQ   = KP_ACQ_DEF,
    parameter int KP_TRK   = KP_TRK_DEF,
    parameter int LF_SH    = 10,
    parameter int FMAX     = 2**26,
    parameter int LOCK_CNT = 1024,
    parameter int LOSS_CNT = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] sigin,
    output logic          out_valid,
    output logic [DW-1:0] demod_out,
    output logic [PW-1:0] freq_adj,
    output logic          locked,
    output logic [1:0]    lock_state
);

    localparam int CW = $clog2((LOCK_CNT > LOSS_CNT ? LOCK_CNT : LOSS_CNT) + 1);
    localparam logic signed [63:0] SMAX = 64'(2**(DW-1) - 1);
    localparam logic signed [63:0] SMIN = -SMAX - 64'sd1;
    localparam logic signed [63:0] FLIM = 64'(FMAX);
    localparam logic [CW-1:0]      LOCK_TH = CW'(LOCK_CNT);
    localparam logic [CW-1:0]      LOSS_TH = CW'(LOSS_CNT);

    logic                 w_vco_s, w_vco_c;
    logic [PW-1:0]        w_incr;
    logic signed [DW-1:0] w_x, w_neg, w_arm_i, w_arm_q;
    logic signed [DW-1:0] w_i_next, w_q_next, w_diff;
    logic signed [63:0]   w_abs_i, w_abs_q, w_kp, w_step;
    logic signed [PW-1:0] w_freq_next;
    logic                 w_pd, w_good;

    logic signed [DW-1:0] r_i, r_q, r_dc, r_demod;
    logic signed [PW-1:0] r_freq;
    logic                 r_v1, r_vout;

    lock_state_t          r_state, w_state_next;
    logic [CW-1:0]        r_cnt, w_cnt_next, w_cnt_inc;

    assign w_incr = PW'(NOM_INCR) + $unsigned(r_freq);

    nco_square #(.PW(PW)) u_nco (
        .clk     (clk),
        .rst     (rst),
        .i_en    (in_valid),
        .i_incr  (w_incr),
        .o_vco_s (w_vco_s),
        .o_vco_c (w_vco_c)
    );

    // Offset-binary in; negating the most negative code clips to full scale.
    assign w_x     = {~sigin[DW-1], sigin[DW-2:0]};
    assign w_neg   = DW'(sat(-64'(w_x), SMIN, SMAX));
    assign w_arm_i = w_vco_c ? w_x : w_neg;
    assign w_arm_q = w_vco_s ? w_x : w_neg;

    assign w_i_next = DW'(sat(64'(r_i) - 64'(r_i >>> LPF_SH) + 64'(w_arm_i >>> LPF_SH), SMIN, SMAX));
    assign w_q_next = DW'(sat(64'(r_q) - 64'(r_q >>> LPF_SH) + 64'(w_arm_q >>> LPF_SH), SMIN, SMAX));

    assign w_abs_i = r_i[DW-1] ? -64'(r_i) : 64'(r_i);
    assign w_abs_q = r_q[DW-1] ? -64'(r_q) : 64'(r_q);
    assign w_good  = w_abs_i >= (w_abs_q <<< 1);

    // Gain follows the registered state, so a transition affects the next sample.
    assign w_pd        = r_i[DW-1] ^ r_q[DW-1];
    assign w_kp        = (r_state == LOCKED) ? 64'(KP_TRK) : 64'(KP_ACQ);
    assign w_step      = w_pd ? w_kp : -w_kp;
    assign w_freq_next = PW'(sat(64'(r_freq) - (64'(r_freq) >>> LF_SH) + (w_step >>> LF_SH),
                                 -FLIM, FLIM));

    assign w_diff = DW'(sat(64'(r_i) - 64'(r_dc), SMIN, SMAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i    <= '0;
            r_q    <= '0;
            r_freq <= '0;
            r_dc   <= '0;
        end else if (in_valid) begin
            r_i    <= w_i_next;
            r_q    <= w_q_next;
            r_freq <= w_freq_next;
            if (r_i > r_dc)      r_dc <= r_dc + DW'(1);
            else if (r_i < r_dc) r_dc <= r_dc - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEARCH;
            r_cnt   <= '0;
        end else if (in_valid) begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
        case (r_state)
            SEARCH: begin
                if (w_good) begin
                    w_state_next = VERIFY;
                    w_cnt_next   = CW'(1);
                end
            end
            VERIFY: begin
                if (!w_good) begin
                    w_state_next = SEARCH;
                    w_cnt_next   = '0;
                end else if (w_cnt_inc >= LOCK_TH) begin
                    w_state_next = LOCKED;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            LOCKED: begin
                if (w_good) begin
                    w_cnt_next   = '0;
                end else if (w_cnt_inc >= LOSS_TH) begin
                    w_state_next = SEARCH;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = SEARCH;
                w_cnt_next   = '0;
            end
        endcase
    end

    // The strobe pipeline runs every cycle so latency stays fixed; data only moves with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_vout  <= 1'b0;
            r_demod <= '0;
        end else begin
            r_v1   <= in_valid;
            r_vout <= r_v1;
            if (r_v1) r_demod <= w_diff;
        end
    end

    assign out_valid  = r_vout;
    assign demod_out  = {~r_demod[DW-1], r_demod[DW-2:0]};
    assign freq_adj   = r_freq;
    assign locked     = (r_state == LOCKED);
    assign lock_state = r_state;

endmodule

// File: tb/tb_costas_demod_v2.sv
// Self-checking bench for costas_demod_v2: integer reference model feeding a
// demod_out scoreboard, plus per-scenario checks of reset, latency and lock FSM.
`timescale 1ns/1ps
module tb_costas_demod_v2;

    localparam int DW = 14, PW = 32, NOM = 919123001, LPF_SH = 2;
    localparam int KPA = 5000000, KPT = 1000000, LF_SH = 10, FMAX = 65536;
    localparam int LOCK_CNT = 16, LOSS_CNT = 8;
    localparam logic [DW-1:0] ZERO = 14'h2000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] sigin = '0;
    logic          out_valid, locked;
    logic [DW-1:0] demod_out;
    logic [PW-1:0] freq_adj;
    logic [1:0]    lock_state;

    int n_tests = 0;
    int n_fail  = 0;
    int q_exp[$];
    int mon_exp;

    longint m_acc, m_i, m_q, m_f, m_dc;
    int     m_state, m_cnt;

    costas_demod_v2 #(
        .DW(DW), .PW(PW), .NOM_INCR(NOM), .LPF_SH(LPF_SH), .KP_ACQ(KPA), .KP_TRK(KPT),
        .LF_SH(LF_SH), .FMAX(FMAX), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sigin(sigin),
        .out_valid(out_valid), .demod_out(demod_out), .freq_adj(freq_adj),
        .locked(locked), .lock_state(lock_state)
    );

    always #5 clk = ~clk;

    function automatic longint satl(input longint v, input longint lo, input longint hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic void model_reset();
        m_acc = 0; m_i = 0; m_q = 0; m_f = 0; m_dc = 0; m_state = 0; m_cnt = 0;
    endfunction

    function automatic void model_step(input int s);
        longint x, ai, aq, ni, nq, kp, stp, ab_i, ab_q;
        bit vs, vc, good, pd;
        x    = longint'(s) - 8192;
        vs   = m_acc[31];
        vc   = m_acc[31] ^ m_acc[30];
        ai   = vc ? x : satl(-x, -8192, 8191);
        aq   = vs ? x : satl(-x, -8192, 8191);
        ab_i = (m_i < 0) ? -m_i : m_i;
        ab_q = (m_q < 0) ? -m_q : m_q;
        good = (ab_i >= 2 * ab_q);
        pd   = (m_i < 0) ^ (m_q < 0);
        kp   = (m_state == 2) ? KPT : KPA;
        stp  = pd ? kp : -kp;
        ni   = satl(m_i - (m_i >>> LPF_SH) + (ai >>> LPF_SH), -8192, 8191);
        nq   = satl(m_q - (m_q >>> LPF_SH) + (aq >>> LPF_SH), -8192, 8191);
        if (m_i > m_dc) m_dc = m_dc + 1;
        else if (m_i < m_dc) m_dc = m_dc - 1;
        m_acc = (m_acc + NOM + m_f) & 64'hFFFF_FFFF;
        m_f   = satl(m_f - (m_f >>> LF_SH) + (stp >>> LF_SH), -FMAX, FMAX);
        case (m_state)
            0: if (good) begin m_state = 1; m_cnt = 1; end
            1: if (!good) begin m_state = 0; m_cnt = 0; end
               else if (m_cnt + 1 >= LOCK_CNT) begin m_state = 2; m_cnt = 0; end
               else m_cnt = m_cnt + 1;
            default: if (good) m_cnt = 0;
               else if (m_cnt + 1 >= LOSS_CNT) begin m_state = 0; m_cnt = 0; end
               else m_cnt = m_cnt + 1;
        endcase
        m_i = ni;
        m_q = nq;
        q_exp.push_back(int'(satl(m_i - m_dc, -8192, 8191)) + 8192);
    endfunction

    task automatic drive(input logic v, input logic [DW-1:0] s);
        @(negedge clk);
        in_valid = v;
        sigin    = s;
        if (v) model_step(int'(s));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        q_exp.delete();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard consumer: every out_valid must match the oldest predicted sample.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            n_tests++;
            if (q_exp.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_out_valid: got out_valid=1 required no output pending");
            end else begin
                mon_exp = q_exp.pop_front();
                if (demod_out !== DW'(mon_exp)) begin
                    n_fail++;
                    $display("FAIL sb_demod_out: got 0x%h required 0x%h", demod_out, DW'(mon_exp));
                end
            end
        end
    end

    task automatic check_model(input string tag);
        n_tests++;
        if (lock_state !== 2'(m_state)) begin
            n_fail++;
            $display("FAIL %s lock_state: got %0d required %0d", tag, lock_state, m_state);
        end
        n_tests++;
        if (freq_adj !== PW'(m_f)) begin
            n_fail++;
            $display("FAIL %s freq_adj: got %0d required %0d", tag, $signed(freq_adj), m_f);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1;
        q_exp.delete();
        model_reset();
        for (int k = 0; k < 5; k++) begin
            sigin = DW'($urandom);
            @(posedge clk); #1;
            n_tests += 5;
            if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
            if (lock_state !== 2'd0) begin n_fail++; $display("FAIL reset_lock_state: got %0d required 0", lock_state); end
            if (locked !== 1'b0)     begin n_fail++; $display("FAIL reset_locked: got %b required 0", locked); end
            if (freq_adj !== '0)     begin n_fail++; $display("FAIL reset_freq_adj: got %0d required 0", freq_adj); end
            if (demod_out !== ZERO)  begin n_fail++; $display("FAIL reset_demod_out: got 0x%h required 0x2000", demod_out); end
            @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            n_tests += 2;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b required 0", out_valid); end
            if (demod_out !== ZERO) begin n_fail++; $display("FAIL post_reset_demod_out: got 0x%h required 0x2000", demod_out); end
        end
    endtask

    task automatic test_latency();
        logic want;
        drive(1'b1, 14'd9192);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            want = (k == 2);
            n_tests++;
            if (out_valid !== want) begin
                n_fail++;
                $display("FAIL latency_cycle%0d: got out_valid=%b required %b", k, out_valid, want);
            end
            if (k == 2) begin
                n_tests++;
                if (demod_out !== 14'd7942) begin n_fail++; $display("FAIL latency_demod: got %0d required 7942", demod_out); end
            end
        end
        n_tests += 2;
        if (freq_adj !== PW'(-4883)) begin n_fail++; $display("FAIL latency_freq_adj: got %0d required -4883", $signed(freq_adj)); end
        if (lock_state !== 2'd1)     begin n_fail++; $display("FAIL latency_lock_state: got %0d required 1", lock_state); end
    endtask

    task automatic test_lock_zero();
        logic [1:0] want;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, ZERO);
            @(posedge clk); #1;
            want = (k >= LOCK_CNT) ? 2'd2 : 2'd1;
            n_tests += 2;
            if (lock_state !== want)        begin n_fail++; $display("FAIL lock_zero_state_s%0d: got %0d required %0d", k, lock_state, want); end
            if (locked !== (want == 2'd2))  begin n_fail++; $display("FAIL lock_zero_locked_s%0d: got %b required %b", k, locked, want == 2'd2); end
        end
        drive(1'b0, ZERO);
        repeat (2) @(negedge clk);
        n_tests += 2;
        if (freq_adj !== PW'(-FMAX)) begin n_fail++; $display("FAIL lock_zero_freq_pinned: got %0d required %0d", $signed(freq_adj), -FMAX); end
        if (demod_out !== ZERO)      begin n_fail++; $display("FAIL lock_zero_demod: got 0x%h required 0x2000", demod_out); end
        check_model("lock_zero");
    endtask

    task automatic test_noise_loss();
        int saw_search = 0;
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 7) != 0), DW'($urandom));
            @(posedge clk); #1;
            check_model("noise");
            if (m_state == 0) saw_search++;
        end
        $display("[TB] noise phase: %0d samples in SEARCH", saw_search);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 14'h0000);
            @(posedge clk); #1;
            check_model("sat_neg_full");
            n_tests++;
            if ($signed(freq_adj) > FMAX || $signed(freq_adj) < -FMAX) begin
                n_fail++;
                $display("FAIL sat_freq_bound: got %0d required within +-%0d", $signed(freq_adj), FMAX);
            end
        end
    endtask

    task automatic test_bpsk();
        real ph;
        int  sym = 1, s;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if (n % 64 == 0) sym = ($urandom_range(0, 1) != 0) ? 1 : -1;
            ph = 2.0 * 3.14159265358979 * (10.705e6 / 100.0e6) * n;
            s  = 8192 + $rtoi(4000.0 * sym * $cos(ph));
            drive(1'b1, DW'(s));
            @(posedge clk); #1;
            check_model("bpsk");
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 200; k++) begin
            drive(($urandom_range(0, 1) != 0), DW'(8192 + $urandom_range(0, 600) - 300));
            @(posedge clk); #1;
            check_model("gaps");
        end
    endtask

    task automatic test_rst_midlock();
        do_reset();
        for (int k = 0; k < LOCK_CNT; k++) drive(1'b1, ZERO);
        drive(1'b1, ZERO);
        @(posedge clk); #1;
        n_tests++;
        if (lock_state !== 2'd2) begin n_fail++; $display("FAIL midlock_locked: got %0d required 2", lock_state); end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1;
        q_exp.delete();
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_tests += 3;
            if (lock_state !== 2'd0) begin n_fail++; $display("FAIL midlock_rst_state: got %0d required 0", lock_state); end
            if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL midlock_discard: got out_valid=%b required 0", out_valid); end
            if (freq_adj !== '0)     begin n_fail++; $display("FAIL midlock_freq: got %0d required 0", $signed(freq_adj)); end
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_latency();
        test_lock_zero();
        test_noise_loss();
        test_saturation();
        test_bpsk();
        test_back_to_back();
        test_rst_midlock();
        drive(1'b0, ZERO);
        repeat (5) @(negedge clk);
        n_tests++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d outputs pending required 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
